// File: rtl/psum_acc_requant_pkg.sv
// psum_acc_requant_pkg: shared widths and FSM state type for the psum accumulate/requant block
package psum_acc_requant_pkg;
   localparam int PSUM_WID  = 32;
   localparam int PROD_WID  = 16;
   localparam int OUT_WID   = 8;
   localparam int SHIFT_WID = 5;
   typedef enum logic [1:0] {IDLE, ACC, REQ, HOLD} state_t;
endpackage

// File: rtl/requant_sat.sv
// requant_sat: rounding arithmetic right shift, optional ReLU, saturation to a signed OUT_WID result
module requant_sat
   import psum_acc_requant_pkg::*;
(
   input  logic [PSUM_WID-1:0]  acc,
   input  logic [SHIFT_WID-1:0] shift,
   input  logic                 relu_en,
   output logic [OUT_WID-1:0]   q
);
   localparam logic signed [PSUM_WID:0] MAX_Q = (PSUM_WID+1)'((1 <<< (OUT_WID-1)) - 1);
   localparam logic signed [PSUM_WID:0] MIN_Q = (PSUM_WID+1)'(-(1 <<< (OUT_WID-1)));
   logic signed [PSUM_WID:0] rnd, t, s, r;
   // one extra bit keeps the rounding increment from overflowing the sum
   always_comb begin
      rnd = (shift == '0) ? '0 : (PSUM_WID+1)'(1) << (shift - SHIFT_WID'(1));
      t = $signed({acc[PSUM_WID-1], acc}) + rnd;
      s = t >>> shift;
      r = (relu_en && s < 0) ? '0 : s;
      q = (r > MAX_Q) ? MAX_Q[OUT_WID-1:0] : (r < MIN_Q) ? MIN_Q[OUT_WID-1:0] : r[OUT_WID-1:0];
   end
endmodule

// File: rtl/psum_acc_requant.sv
// psum_acc_requant: accumulate signed products onto a seed, then requantise to int8 behind valid/ready
module psum_acc_requant
   import psum_acc_requant_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PSUM_WID-1:0]  init_val,
   input  logic                 start,
   input  logic                 prod_valid,
   input  logic [PROD_WID-1:0]  prod,
   input  logic                 prod_last,
   input  logic [SHIFT_WID-1:0] shift_amt,
   input  logic                 relu_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WID-1:0]   out_data,
   output logic [PSUM_WID-1:0]  psum_out,
   output logic                 busy
);
   state_t state, state_nxt;
   logic [PSUM_WID-1:0] acc;
   logic [SHIFT_WID-1:0] shift_q;
   logic relu_q, load;
   logic [OUT_WID-1:0] q;
   requant_sat u_sat (.acc(acc), .shift(shift_q), .relu_en(relu_q), .q(q));
   // a start accepted together with the output handshake chains jobs with no idle bubble
   always_comb begin
      state_nxt = state;
      load = 1'b0;
      case (state)
         IDLE: begin
            load = start;
            state_nxt = start ? ACC : IDLE;
         end
         ACC: state_nxt = (prod_valid && prod_last) ? REQ : ACC;
         REQ: state_nxt = HOLD;
         HOLD: begin
            load = out_ready && start;
            state_nxt = out_ready ? (start ? ACC : IDLE) : HOLD;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc <= '0;
         shift_q <= '0;
         relu_q <= 1'b0;
         out_data <= '0;
         psum_out <= '0;
         out_valid <= 1'b0;
         busy <= 1'b0;
      end else begin
         state <= state_nxt;
         busy <= state_nxt != IDLE;
         out_valid <= state_nxt == HOLD;
         if (load) begin
            acc <= init_val;
            shift_q <= shift_amt;
            relu_q <= relu_en;
         end else if (state == ACC && prod_valid) begin
            acc <= acc + {{(PSUM_WID-PROD_WID){prod[PROD_WID-1]}}, prod};
         end
         if (state == REQ) begin
            out_data <= q;
            psum_out <= acc;
         end
      end
   end
endmodule

// File: tb/tb_psum_acc_requant.sv
// tb_psum_acc_requant: directed plan cases plus randomized jobs checked against an arithmetic reference model
module tb_psum_acc_requant;
   logic clk = 1'b0, rst = 1'b1;
   logic [31:0] init_val = '0;
   logic start = 1'b0, prod_valid = 1'b0, prod_last = 1'b0, relu_en = 1'b0, out_ready = 1'b0;
   logic [15:0] prod = '0;
   logic [4:0] shift_amt = '0;
   logic out_valid, busy;
   logic [7:0] out_data;
   logic [31:0] psum_out;
   int n_cmp = 0, n_err = 0;
   shortint prods[$];
   int exp_psum;
   longint exp_out;
   bit pending;

   psum_acc_requant dut (
      .clk(clk), .rst(rst), .init_val(init_val), .start(start), .prod_valid(prod_valid),
      .prod(prod), .prod_last(prod_last), .shift_amt(shift_amt), .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .psum_out(psum_out), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // wrap-around int sum, then round-half-up division by 2^sh on a wide integer
   function automatic void model(input int init, input int sh, input bit relu);
      int s;
      longint t;
      s = init;
      foreach (prods[i]) s += int'(prods[i]);
      exp_psum = s;
      t = longint'(s) + ((sh > 0) ? (longint'(1) << (sh - 1)) : 64'sd0);
      t = t >>> sh;
      if (relu && t < 0) t = 0;
      if (t > 127) t = 127;
      if (t < -128) t = -128;
      exp_out = t;
   endfunction

   task automatic begin_job(input int init, input int sh, input bit relu, input bit from_hold);
      start = 1'b1;
      init_val = init;
      shift_amt = 5'(sh);
      relu_en = relu;
      out_ready = from_hold;
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = 1'b0;
      init_val = $urandom;
      shift_amt = 5'($urandom);
      relu_en = 1'($urandom);
      check("busy_acc", busy, 1);
      check("valid_acc", out_valid, 0);
      model(init, sh, relu);
   endtask

   task automatic feed(input int gap, input bit junk_start);
      foreach (prods[i]) begin
         prod_valid = 1'b1;
         prod = prods[i];
         prod_last = (i == prods.size() - 1);
         @(posedge clk); #1;
         prod_valid = 1'b0;
         prod = 16'($urandom);
         prod_last = 1'($urandom);
         if (i < prods.size() - 1)
            repeat (gap) begin
               start = junk_start;
               init_val = $urandom;
               @(posedge clk); #1;
            end
         start = 1'b0;
      end
      prod_last = 1'b0;
      check("valid_n1", out_valid, 0);
      check("busy_n1", busy, 1);
      @(posedge clk); #1;
      check("valid_n2", out_valid, 1);
      check("out_data", longint'($signed(out_data)), exp_out);
      check("psum_out", longint'($signed(psum_out)), exp_psum);
   endtask

   task automatic hold(input int n);
      repeat (n) begin
         out_ready = 1'b0;
         start = 1'($urandom);
         init_val = $urandom;
         @(posedge clk); #1;
         check("hold_valid", out_valid, 1);
         check("hold_busy", busy, 1);
         check("hold_data", longint'($signed(out_data)), exp_out);
         check("hold_psum", longint'($signed(psum_out)), exp_psum);
      end
      start = 1'b0;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("rel_valid", out_valid, 0);
      check("rel_busy", busy, 0);
   endtask

   task automatic job(input int init, input int sh, input bit relu, input int gap, input int nhold);
      begin_job(init, sh, relu, 1'b0);
      feed(gap, 1'b1);
      hold(nhold);
      release_out();
   endtask

   initial begin
      int sh, n, init;
      bit relu;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_data", out_data, 0);
      check("rst_psum", psum_out, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      prod_valid = 1'b1;
      prod_last = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      prod_valid = 1'b0;
      prod_last = 1'b0;
      check("idle_ignore_busy", busy, 0);
      check("idle_ignore_valid", out_valid, 0);

      prods = '{256, -128};
      job(32'h0000_1000, 8, 1'b0, 0, 0);
      prods = '{0};
      job(32'hFFFF_FB00, 8, 1'b0, 0, 0);
      job(32'hFFFF_FB00, 8, 1'b1, 0, 0);
      job(32'h0010_0000, 8, 1'b0, 0, 0);
      prods = '{16'sh0100};
      job(32'h7FFF_FF00, 8, 1'b0, 0, 0);

      prods = '{1000, -3000, 77, 12345};
      begin_job(32'h0000_2000, 6, 1'b0, 1'b0);
      feed(0, 1'b0);
      hold(3);
      prods = '{-500, 31};
      begin_job(-32'sd7000, 4, 1'b1, 1'b1);
      feed(2, 1'b1);
      release_out();

      prods = '{100, 200, 300, 400};
      begin_job(32'h0000_0500, 3, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         prod_valid = 1'b1;
         prod = prods[i];
         @(posedge clk); #1;
      end
      prod_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_data", out_data, 0);
      check("mid_rst_psum", psum_out, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      prods = '{-9, 5};
      job(32'h0000_0040, 2, 1'b0, 1, 1);

      pending = 1'b0;
      for (int k = 0; k < 60; k++) begin
         n = $urandom_range(1, 6);
         prods = {};
         for (int i = 0; i < n; i++) prods.push_back(shortint'($urandom));
         init = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 80000)) - 40000;
         sh = $urandom_range(0, 31);
         relu = 1'($urandom);
         if (pending && $urandom_range(0, 1)) begin
            begin_job(init, sh, relu, 1'b1);
         end else begin
            if (pending) release_out();
            begin_job(init, sh, relu, 1'b0);
         end
         feed($urandom_range(0, 2), 1'($urandom));
         hold($urandom_range(0, 3));
         pending = 1'b1;
      end
      release_out();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
